// File: rtl/doorlock_pkg.sv
// Shared types and helpers for the door-lock keypad blocks (controller,
// display driver, encoder wrapper).
package doorlock_pkg;

    localparam int KEY_W = 4;
    localparam logic [KEY_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    // Encoder codes 10..15 are not digits and must never reach the buffer.
    function automatic logic bcd_valid(input logic [KEY_W-1:0] code);
        return code <= BCD_MAX;
    endfunction

endpackage

// File: rtl/doorlock_timer.sv
// Loadable down-counter shared by the open, lockout and entry-timeout phases.
// Holds at zero; done is high while the count is zero.
module doorlock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load takes priority over counting; count stops at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/doorlock_keypad_ctrl.sv
// Keypad sequencer: buffers BCD digits, checks the code on enter, drives the
// door release, counts consecutive failures and enforces a timed lockout.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | no entry in progress, waiting for the first digit
//  ENTRY   | collecting digits, entry timeout running
//  CHECK   | one cycle: compare buffer against stored password
//  OPEN    | unlock high, new password may be entered
//  LOCKOUT | alarm high, all keys ignored until the lockout timer expires
module doorlock_keypad_ctrl
    import doorlock_pkg::*;
#(
    parameter int                  DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_PW  = 16'h1234,
    parameter int                  OPEN_CYCLES = 1000,
    parameter int                  LOCK_CYCLES = 5000,
    parameter int                  IDLE_CYCLES = 3000,
    parameter int                  MAX_FAIL    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [KEY_W-1:0]      key_code,
    input  logic                  key_enter,
    input  logic                  key_clear,
    output logic                  unlock,
    output logic                  alarm,
    output logic                  fail_pulse,
    output logic                  pw_changed,
    output logic [3:0]            digit_cnt,
    output logic [4*DIGITS-1:0]   entry_buf,
    output logic [2:0]            state_o
);

    localparam int BUF_W   = 4 * DIGITS;
    localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES)
                           ? ((OPEN_CYCLES > IDLE_CYCLES) ? OPEN_CYCLES : IDLE_CYCLES)
                           : ((LOCK_CYCLES > IDLE_CYCLES) ? LOCK_CYCLES : IDLE_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    // Timers are loaded with N-1 so the phase lasts exactly N cycles,
    // leaving on the cycle the count reads zero.
    localparam logic [TMR_W-1:0] OPEN_LD  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LD  = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] IDLE_LD  = TMR_W'(IDLE_CYCLES - 1);
    localparam logic [3:0]       CNT_FULL = 4'(DIGITS);
    localparam logic [2:0]       FAIL_LIM = 3'(MAX_FAIL);

    state_t             state;
    logic               overflow;
    logic [2:0]         fail_cnt;
    logic [2:0]         fail_next;
    logic [BUF_W-1:0]   password;
    logic [BUF_W-1:0]   buf_push;
    logic               clr_ev, ent_ev, dig_ev, dig_ok;
    logic               can_store, match;
    logic               tmr_load, tmr_done;
    logic [TMR_W-1:0]   tmr_val;

    // Strobe priority: clear beats enter beats digit.
    assign clr_ev    = key_clear;
    assign ent_ev    = key_enter && !key_clear;
    assign dig_ev    = key_valid && !key_enter && !key_clear;
    assign dig_ok    = dig_ev && bcd_valid(key_code);

    assign buf_push  = (entry_buf << 4) | BUF_W'(key_code);
    assign can_store = (digit_cnt == CNT_FULL) && !overflow;
    assign match     = can_store && (entry_buf == password);
    assign fail_next = fail_cnt + 3'd1;
    assign state_o   = state;

    // Timer reload points: entry keystrokes, the check decision, and a
    // password change that restarts the open window.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = IDLE_LD;
        case (state)
            IDLE:    tmr_load = dig_ok;
            ENTRY:   tmr_load = dig_ev;
            CHECK: begin
                tmr_load = 1'b1;
                tmr_val  = match ? OPEN_LD : LOCK_LD;
            end
            OPEN: begin
                tmr_load = ent_ev && can_store;
                tmr_val  = OPEN_LD;
            end
            default: tmr_load = 1'b0;
        endcase
    end

    doorlock_timer #(.W(TMR_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    // Main sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            unlock     <= 1'b0;
            alarm      <= 1'b0;
            fail_pulse <= 1'b0;
            pw_changed <= 1'b0;
            digit_cnt  <= '0;
            entry_buf  <= '0;
            overflow   <= 1'b0;
            fail_cnt   <= '0;
            password   <= DEFAULT_PW;
        end else begin
            fail_pulse <= 1'b0;
            pw_changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (dig_ok) begin
                        entry_buf <= BUF_W'(key_code);
                        digit_cnt <= 4'd1;
                        overflow  <= 1'b0;
                        state     <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (clr_ev || (!ent_ev && !dig_ev && tmr_done)) begin
                        entry_buf <= '0;
                        digit_cnt <= '0;
                        overflow  <= 1'b0;
                        state     <= IDLE;
                    end else if (ent_ev) begin
                        state <= CHECK;
                    end else if (dig_ok) begin
                        if (digit_cnt < CNT_FULL) begin
                            entry_buf <= buf_push;
                            digit_cnt <= digit_cnt + 4'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    entry_buf <= '0;
                    digit_cnt <= '0;
                    overflow  <= 1'b0;
                    if (match) begin
                        fail_cnt <= '0;
                        unlock   <= 1'b1;
                        state    <= OPEN;
                    end else begin
                        fail_pulse <= 1'b1;
                        fail_cnt   <= fail_next;
                        if (fail_next == FAIL_LIM) begin
                            alarm <= 1'b1;
                            state <= LOCKOUT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                OPEN: begin
                    if (clr_ev || ent_ev) begin
                        if (ent_ev && can_store) begin
                            password   <= entry_buf;
                            pw_changed <= 1'b1;
                        end
                        entry_buf <= '0;
                        digit_cnt <= '0;
                        overflow  <= 1'b0;
                    end else if (dig_ok) begin
                        if (digit_cnt < CNT_FULL) begin
                            entry_buf <= buf_push;
                            digit_cnt <= digit_cnt + 4'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    // A password store on the last cycle restarts the window instead of closing.
                    if (tmr_done && !(ent_ev && can_store)) begin
                        unlock    <= 1'b0;
                        entry_buf <= '0;
                        digit_cnt <= '0;
                        overflow  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                LOCKOUT: begin
                    if (tmr_done) begin
                        alarm    <= 1'b0;
                        fail_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
